dmem_unit: RTL

DMEM_UNIT -- requirements
Module: dmem_unit

---
 rtl/dmem_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_unit.sv
// -----------------------------------------------------------------------------
// dmem_unit -- single-outstanding-load data memory with committed-store port.
//
// A load is accepted in IDLE, waits LATENCY cycles in a down-counter, reads
// the word array on the WAIT->RESP edge and presents one response cycle in
// RESP. Stores write on any cycle with byte enables derived from st_func3.
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned loads
// (mem_err=1, mem_data=0) and drop misaligned stores. Without it, mem_err is
// tied low and misaligned accesses align down.
//
// Ports:
//   clk, reset (sync active-low)
//   load_mem, ld_addr, ld_func3, ld_pd, ld_rob_tag   load request
//   store_wb, st_addr, st_data, st_func3              committed store
//   mispredict                                        flush in-flight load
//   load_ready                                        load acceptance
//   mem_valid, mem_rob_tag, mem_pd, mem_data, mem_err load response
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | no load in flight, accepting when not flushed
// WAIT  | load latched, latency counter running
// RESP  | one-cycle response strobe
module dmem_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_mem,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_func3,
  input  logic [6:0]  ld_pd,
  input  logic [4:0]  ld_rob_tag,
  input  logic        store_wb,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_func3,
  input  logic        mispredict,
  output logic        load_ready,
  output logic        mem_valid,
  output logic [4:0]  mem_rob_tag,
  output logic [6:0]  mem_pd,
  output logic [31:0] mem_data,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic [AW+1:0]   ld_addr_q;
  logic [2:0]      ld_func3_q;
  logic [6:0]      ld_pd_q;
  logic [4:0]      ld_tag_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            read_en;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic            st_misalign;
  logic            ld_misalign;
  logic [31:0]     ld_ext;

  // Upper address bits wrap away; collected here so they are visibly unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[31:AW+2], st_addr[31:AW+2]};

  assign load_ready = (state_q == S_IDLE) && !mispredict;
  assign accept     = load_mem && load_ready;
  assign read_en    = (state_q == S_WAIT) && (cnt_q == 4'd0) && !mispredict;

  // State register plus the counter and request latches it owns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      ld_addr_q  <= '0;
      ld_func3_q <= 3'd0;
      ld_pd_q    <= 7'd0;
      ld_tag_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q      <= 4'(LATENCY - 1);
        ld_addr_q  <= ld_addr[AW+1:0];
        ld_func3_q <= ld_func3;
        ld_pd_q    <= ld_pd;
        ld_tag_q   <= ld_rob_tag;
      end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (mispredict) state_d = S_IDLE;
               else if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data;
    case (st_func3)
      3'b000: begin
        st_be    = 4'b0001 << st_addr[1:0];
        st_wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        st_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      3'b010:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign st_misalign = ((st_func3 == 3'b001) && st_addr[0]) ||
                       ((st_func3 == 3'b010) && (st_addr[1:0] != 2'b00));
  // Unlisted load encodings behave as lw, so they share the word check.
  always_comb begin
    case (ld_func3_q)
      3'b000, 3'b100: ld_misalign = 1'b0;
      3'b001, 3'b101: ld_misalign = ld_addr_q[0];
      default:        ld_misalign = (ld_addr_q[1:0] != 2'b00);
    endcase
  end
`else
  assign st_misalign = 1'b0;
  assign ld_misalign = 1'b0;
`endif

  // Array has no reset; stores during reset are dropped. Read and write use
  // the same edge with non-blocking updates, giving read-before-write.
  always_ff @(posedge clk) begin
    if (reset && store_wb && !st_misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[st_addr[AW+1:2]][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)       rdata_q <= 32'd0;
    else if (read_en) rdata_q <= mem_q[ld_addr_q[AW+1:2]];
  end

  always_comb begin
    case (ld_func3_q)
      3'b000:  ld_ext = {{24{rdata_q[8*ld_addr_q[1:0] + 7]}}, rdata_q[8*ld_addr_q[1:0] +: 8]};
      3'b100:  ld_ext = {24'd0, rdata_q[8*ld_addr_q[1:0] +: 8]};
      3'b001:  ld_ext = {{16{rdata_q[16*ld_addr_q[1] + 15]}}, rdata_q[16*ld_addr_q[1] +: 16]};
      3'b101:  ld_ext = {16'd0, rdata_q[16*ld_addr_q[1] +: 16]};
      default: ld_ext = rdata_q;
    endcase
  end

  // Output logic: response fields are zero outside the RESP cycle.
  always_comb begin
    mem_valid   = 1'b0;
    mem_rob_tag = 5'd0;
    mem_pd      = 7'd0;
    mem_data    = 32'd0;
    mem_err     = 1'b0;
    if (state_q == S_RESP) begin
      mem_valid   = 1'b1;
      mem_rob_tag = ld_tag_q;
      mem_pd      = ld_pd_q;
      mem_err     = ld_misalign;
      mem_data    = ld_misalign ? 32'd0 : ld_ext;
    end
  end

endmodule
